// File: rtl/fb_write_sink.sv
// fb_write_sink: queues rasterizer pixel writes and retires them to the frame-buffer SRAM, plus whole-frame clear.
// Define FB_DROP_COUNT_EN to add O_DROP_COUNT, a saturating count of out-of-range writes.
module fb_write_sink #(
   parameter int unsigned ADDR_WIDTH = 18,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned NUM_PIXELS = 256000
) (
   input  logic                  I_CLOCK,
   input  logic                  I_RESET_N,
   input  logic                  I_WR_VALID,
   input  logic [ADDR_WIDTH-1:0] I_WR_ADDR,
   input  logic [63:0]           I_WR_COLOR,
   output logic                  O_WR_READY,
   input  logic                  I_CLEAR,
   input  logic [15:0]           I_CLEAR_COLOR,
   input  logic                  I_SRAM_GRANT,
   output logic                  O_SRAM_REQ,
   output logic [ADDR_WIDTH-1:0] O_SRAM_ADDR,
   output logic [15:0]           O_SRAM_DQ,
   output logic                  O_SRAM_CE_N,
   output logic                  O_SRAM_WE_N,
   output logic                  O_BUSY
`ifdef FB_DROP_COUNT_EN
   ,
   output logic [15:0]           O_DROP_COUNT
`endif
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, CLR_SETUP, CLR_STROBE} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH+15:0]  mem_q [FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
   logic [PW:0]             cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic                    clr_pend_q, clr_pend_d;
   logic [15:0]             clr_color_q, clr_color_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [15:0]             dq_q, dq_d;
   logic                    ce_n_q, ce_n_d;
   logic                    we_n_q, we_n_d;
   logic                    accept, in_range, push, pop;
   logic                    unused_color_hi;

   assign unused_color_hi = ^I_WR_COLOR[63:16];
   assign accept   = I_WR_VALID && ready_q;
   assign in_range = (I_WR_ADDR <= LAST_ADDR);
   assign push     = accept && in_range;
   assign cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      dq_d        = dq_q;
      ce_n_d      = ce_n_q;
      we_n_d      = we_n_q;
      pop         = 1'b0;
      clr_pend_d  = clr_pend_q;
      clr_color_d = clr_color_q;
      if (I_CLEAR && !clr_pend_q) begin
         clr_pend_d  = 1'b1;
         clr_color_d = I_CLEAR_COLOR;
      end
      unique case (state_q)
         // Queued writes keep draining while a clear is pending; the clear starts once empty.
         IDLE: if (I_SRAM_GRANT) begin
            if (cnt_q != '0) begin
               pop             = 1'b1;
               state_d         = SETUP;
               {addr_d, dq_d}  = mem_q[rd_ptr_q];
               ce_n_d          = 1'b0;
               we_n_d          = 1'b1;
            end else if (clr_pend_q) begin
               state_d = CLR_SETUP;
               addr_d  = '0;
               dq_d    = clr_color_q;
               ce_n_d  = 1'b0;
               we_n_d  = 1'b1;
            end
         end
         SETUP: begin
            state_d = STROBE;
            we_n_d  = 1'b0;
         end
         STROBE: begin
            state_d = IDLE;
            ce_n_d  = 1'b1;
            we_n_d  = 1'b1;
         end
         // CE_N high here means the next clear pixel is still waiting for a grant.
         CLR_SETUP: begin
            if (!ce_n_q) begin
               state_d = CLR_STROBE;
               we_n_d  = 1'b0;
            end else if (I_SRAM_GRANT) begin
               ce_n_d = 1'b0;
            end
         end
         CLR_STROBE: begin
            ce_n_d = 1'b1;
            we_n_d = 1'b1;
            if (addr_q == LAST_ADDR) begin
               state_d    = IDLE;
               clr_pend_d = 1'b0;
            end else begin
               state_d = CLR_SETUP;
               addr_d  = addr_q + ADDR_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (cnt_d != (PW+1)'(FIFO_DEPTH)) && !clr_pend_d
                && (state_d != CLR_SETUP) && (state_d != CLR_STROBE);
   end

   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         ready_q     <= 1'b0;
         clr_pend_q  <= 1'b0;
         clr_color_q <= '0;
         addr_q      <= '0;
         dq_q        <= '0;
         ce_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         clr_pend_q  <= clr_pend_d;
         clr_color_q <= clr_color_d;
         addr_q      <= addr_d;
         dq_q        <= dq_d;
         ce_n_q      <= ce_n_d;
         we_n_q      <= we_n_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   always_ff @(negedge I_CLOCK) begin
      if (push) mem_q[wr_ptr_q] <= {I_WR_ADDR, I_WR_COLOR[15:0]};
   end

`ifdef FB_DROP_COUNT_EN
   logic [15:0] drop_cnt_q;
   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) drop_cnt_q <= '0;
      else if (accept && !in_range && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
   end
   assign O_DROP_COUNT = drop_cnt_q;
`endif

   assign O_WR_READY  = ready_q;
   assign O_SRAM_REQ  = (cnt_q != '0) || (state_q == CLR_SETUP) || (state_q == CLR_STROBE);
   assign O_SRAM_ADDR = addr_q;
   assign O_SRAM_DQ   = dq_q;
   assign O_SRAM_CE_N = ce_n_q;
   assign O_SRAM_WE_N = we_n_q;
   assign O_BUSY      = (cnt_q != '0) || (state_q != IDLE) || clr_pend_q;
endmodule

// File: tb/tb_fb_write_sink.sv
// Scoreboard bench for fb_write_sink: stimulus queues expected SRAM writes, a monitor retires and checks them.
// Runs with a reduced frame (NUM_PIXELS=400) so whole-frame clears stay short.
module tb_fb_write_sink;
   localparam int NP = 400;

   typedef struct {
      logic [17:0] a;
      logic [15:0] d;
      bit          last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        I_WR_VALID = 1'b0;
   logic [17:0] I_WR_ADDR = '0;
   logic [63:0] I_WR_COLOR = '0;
   logic        O_WR_READY;
   logic        I_CLEAR = 1'b0;
   logic [15:0] I_CLEAR_COLOR = '0;
   logic        I_SRAM_GRANT = 1'b0;
   logic        O_SRAM_REQ;
   logic [17:0] O_SRAM_ADDR;
   logic [15:0] O_SRAM_DQ;
   logic        O_SRAM_CE_N;
   logic        O_SRAM_WE_N;
   logic        O_BUSY;
`ifdef FB_DROP_COUNT_EN
   logic [15:0] O_DROP_COUNT;
`endif

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   gmode = 0;
   int   clr_issued = 0;
   int   clr_done = 0;
   int   drops_m = 0;

   fb_write_sink #(.ADDR_WIDTH(18), .FIFO_DEPTH(8), .NUM_PIXELS(NP)) dut (
      .I_CLOCK(clk), .I_RESET_N(rst_n),
      .I_WR_VALID(I_WR_VALID), .I_WR_ADDR(I_WR_ADDR), .I_WR_COLOR(I_WR_COLOR),
      .O_WR_READY(O_WR_READY), .I_CLEAR(I_CLEAR), .I_CLEAR_COLOR(I_CLEAR_COLOR),
      .I_SRAM_GRANT(I_SRAM_GRANT), .O_SRAM_REQ(O_SRAM_REQ), .O_SRAM_ADDR(O_SRAM_ADDR),
      .O_SRAM_DQ(O_SRAM_DQ), .O_SRAM_CE_N(O_SRAM_CE_N), .O_SRAM_WE_N(O_SRAM_WE_N),
      .O_BUSY(O_BUSY)
`ifdef FB_DROP_COUNT_EN
      , .O_DROP_COUNT(O_DROP_COUNT)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endfunction

   // Grant source: 0 = withheld, 1 = always, otherwise random per cycle.
   initial forever begin
      @(posedge clk); #1;
      case (gmode)
         0:       I_SRAM_GRANT = 1'b0;
         1:       I_SRAM_GRANT = 1'b1;
         default: I_SRAM_GRANT = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: one WE_N-low cycle per retired write; CE_N must frame it for exactly two cycles.
   initial begin
      int ce_len;
      int we_len;
      exp_t e;
      ce_len = 0;
      we_len = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            ce_len = 0;
            we_len = 0;
         end else begin
            if (clr_issued != clr_done) chk("ready_during_clear", O_WR_READY, 0);
            if (!O_SRAM_CE_N) ce_len++;
            if (!O_SRAM_WE_N) begin
               we_len++;
               chk("we_inside_ce", O_SRAM_CE_N, 0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got addr %0h dq %0h expected none", O_SRAM_ADDR, O_SRAM_DQ);
               end else begin
                  e = exp_q.pop_front();
                  chk("sram_addr", O_SRAM_ADDR, e.a);
                  chk("sram_dq", O_SRAM_DQ, e.d);
                  if (e.last) clr_done++;
               end
            end
            if (O_SRAM_CE_N && ce_len != 0) begin
               chk("ce_low_cycles", ce_len, 2);
               chk("we_low_cycles", we_len, 1);
               ce_len = 0;
               we_len = 0;
            end
         end
      end
   end

   task automatic clear_model(input logic [15:0] cc);
      if (clr_issued == clr_done) begin
         for (int i = 0; i < NP; i++) exp_q.push_back('{a: 18'(i), d: cc, last: (i == NP - 1)});
         clr_issued++;
      end
   endtask

   task automatic write_px(input logic [17:0] a, input logic [15:0] c, input bit with_clr, input logic [15:0] cc);
      int n;
      @(posedge clk); #1;
      I_WR_VALID = 1'b1;
      I_WR_ADDR  = a;
      I_WR_COLOR = {32'($urandom), 16'($urandom), c};
      for (n = 0; n < 2000; n++) begin
         if (O_WR_READY) break;
         @(posedge clk); #1;
      end
      if (n == 2000) begin
         chk("write_accept_timeout", 0, 1);
         I_WR_VALID = 1'b0;
         return;
      end
      if (with_clr) begin
         I_CLEAR       = 1'b1;
         I_CLEAR_COLOR = cc;
      end
      @(negedge clk); #1;
      I_WR_VALID = 1'b0;
      I_CLEAR    = 1'b0;
      if (a < 18'(NP)) exp_q.push_back('{a: a, d: c, last: 1'b0});
      else drops_m++;
      if (with_clr) clear_model(cc);
   endtask

   task automatic pulse_clear(input logic [15:0] cc);
      @(posedge clk); #1;
      I_CLEAR       = 1'b1;
      I_CLEAR_COLOR = cc;
      @(negedge clk); #1;
      I_CLEAR = 1'b0;
      clear_model(cc);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      for (n = 0; n < budget; n++) begin
         @(posedge clk); #1;
         if (!O_BUSY && exp_q.size() == 0) break;
      end
      chk(name, 64'(exp_q.size()), 0);
      chk("busy_low_when_drained", O_BUSY, 0);
      chk("req_low_when_drained", O_SRAM_REQ, 0);
   endtask

   task automatic set_grant(input int m);
      gmode = m;
      @(posedge clk); @(posedge clk);
   endtask

   task automatic async_reset_check();
      #1 rst_n = 1'b0;
      #1;
      chk("rst_ce_n", O_SRAM_CE_N, 1);
      chk("rst_we_n", O_SRAM_WE_N, 1);
      chk("rst_ready", O_WR_READY, 0);
      chk("rst_busy", O_BUSY, 0);
      chk("rst_req", O_SRAM_REQ, 0);
      exp_q.delete();
      clr_issued = clr_done;
      drops_m = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int n;
      logic [17:0] a;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_ready", O_WR_READY, 0);
      chk("reset_req", O_SRAM_REQ, 0);
      chk("reset_addr", O_SRAM_ADDR, 0);
      chk("reset_dq", O_SRAM_DQ, 0);
      chk("reset_ce_n", O_SRAM_CE_N, 1);
      chk("reset_we_n", O_SRAM_WE_N, 1);
      chk("reset_busy", O_BUSY, 0);
`ifdef FB_DROP_COUNT_EN
      chk("reset_drop_count", O_DROP_COUNT, 0);
`endif
      #19 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_before_first_edge", O_WR_READY, 0);
      @(posedge clk); #1;
      chk("ready_after_first_edge", O_WR_READY, 1);

      // Single write with a standing grant: BUSY drops three edges after the pop.
      set_grant(1);
      write_px(18'h00123, 16'hF81F, 1'b0, '0);
      for (n = 1; n <= 20; n++) begin
         @(posedge clk);
         if (!O_BUSY) break;
      end
      chk("busy_latency", n, 4);
      wait_idle("single_write", 50);

      // Fill the FIFO without grant; the ninth write must stall.
      set_grant(0);
      for (int i = 0; i < 8; i++) write_px(18'($urandom_range(0, NP - 1)), 16'($urandom), 1'b0, '0);
      @(posedge clk); #1;
      chk("ready_when_full", O_WR_READY, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("no_start_without_grant", O_SRAM_CE_N, 1);
         chk("req_while_queued", O_SRAM_REQ, 1);
      end
      set_grant(1);
      write_px(18'($urandom_range(0, NP - 1)), 16'($urandom), 1'b0, '0);
      wait_idle("full_fifo_drain", 200);

      // Address boundary: NP is dropped, NP-1 is written.
      write_px(18'(NP), 16'h1234, 1'b0, '0);
      write_px(18'(NP - 1), 16'hABCD, 1'b0, '0);
      wait_idle("boundary", 50);
`ifdef FB_DROP_COUNT_EN
      chk("drop_count_boundary", O_DROP_COUNT, 64'(drops_m));
`endif

      // Three queued writes, then a clear: writes retire first, then the whole frame.
      set_grant(0);
      for (int i = 0; i < 3; i++) write_px(18'($urandom_range(0, NP - 1)), 16'($urandom), 1'b0, '0);
      pulse_clear(16'h0000);
      @(posedge clk); #1;
      chk("ready_after_clear_req", O_WR_READY, 0);
      set_grant(1);
      repeat (150) @(posedge clk);
      pulse_clear(16'h5555);
      wait_idle("clear_after_writes", 3000);

      // Write and clear on the same edge, under random grant.
      set_grant(2);
      write_px(18'($urandom_range(0, NP - 1)), 16'h0F0F, 1'b1, 16'hC3C3);
      wait_idle("write_then_clear", 6000);

      // Random traffic including out-of-range addresses.
      for (int i = 0; i < 40; i++) begin
         write_px(18'($urandom_range(0, NP + 20)), 16'($urandom), 1'b0, '0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      wait_idle("random_traffic", 1000);
`ifdef FB_DROP_COUNT_EN
      chk("drop_count_random", O_DROP_COUNT, 64'(drops_m));
`endif

      // Reset during SETUP of a pixel write.
      set_grant(1);
      write_px(18'h00042, 16'h7777, 1'b0, '0);
      for (n = 0; n < 20; n++) begin
         if (!O_SRAM_CE_N) break;
         @(posedge clk); #1;
      end
      chk("setup_reached", O_SRAM_CE_N, 0);
      async_reset_check();
      repeat (5) @(posedge clk);
      #1 chk("idle_after_setup_reset", O_BUSY, 0);

      // Reset mid-clear at pixel 100: the clear must not resume.
      pulse_clear(16'hFFFF);
      for (n = 0; n < 2000; n++) begin
         @(posedge clk); #1;
         if (O_SRAM_ADDR == 18'd100 && !O_SRAM_CE_N) break;
      end
      chk("clear_reached_100", O_SRAM_ADDR, 100);
      async_reset_check();
      repeat (10) @(posedge clk);
      #1;
      chk("clear_aborted_busy", O_BUSY, 0);
      chk("clear_aborted_req", O_SRAM_REQ, 0);
      a = 18'(NP - 2);
      write_px(a, 16'h2468, 1'b0, '0);
      wait_idle("write_after_abort", 50);
`ifdef FB_DROP_COUNT_EN
      chk("drop_count_after_reset", O_DROP_COUNT, 64'(drops_m));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached with %0d expected writes outstanding", exp_q.size());
      $fatal(1, "watchdog");
   end
endmodule
